// File: rtl/burst_rr_scheduler_if.sv
// Requester/scheduler handshake bundle for burst_rr_scheduler.
// The master side drives requests and beat qualifiers; the slave side is the scheduler.
interface burst_rr_scheduler_if #(
    parameter int PORTS     = 4,
    parameter int MAX_BURST = 8
);
    localparam int IDX_W = $clog2(PORTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [PORTS-1:0] i_req_vec;
    logic             i_ready;
    logic             i_last;
    logic [PORTS-1:0] o_grant_vec;
    logic [IDX_W-1:0] o_grant_idx;
    logic             o_grant_valid;
    logic [CNT_W-1:0] o_beat_cnt;
    logic             o_preempt;

    modport master (
        output i_req_vec, i_ready, i_last,
        input  o_grant_vec, o_grant_idx, o_grant_valid, o_beat_cnt, o_preempt
    );

    modport slave (
        input  i_req_vec, i_ready, i_last,
        output o_grant_vec, o_grant_idx, o_grant_valid, o_beat_cnt, o_preempt
    );
endinterface

// File: rtl/burst_rr_scheduler.sv
// Burst-granular round-robin scheduler: one port owns the resource until it releases,
// signals last, or exhausts its MAX_BURST quota; one idle cycle separates grants.
module burst_rr_scheduler #(
    parameter int PORTS     = 4,
    parameter int MAX_BURST = 8
) (
    input logic                i_clk,
    input logic                i_rstn,
    burst_rr_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(PORTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [PORTS-1:0] r_grant_vec;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_valid;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_preempt;
    logic [IDX_W-1:0] r_last_idx;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] cand;
    logic             own_req;
    logic             beat;
    logic             at_quota;
    logic             grant_end;
    logic             preempt_nxt;

    // Scan downward in rotation distance so the nearest requester after r_last_idx wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = IDX_W'((int'(r_last_idx) + k) % PORTS);
            if (bus.i_req_vec[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign own_req     = bus.i_req_vec[r_grant_idx];
    assign beat        = r_grant_valid & own_req & bus.i_ready;
    assign at_quota    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign grant_end   = !own_req | (beat & bus.i_last) | (beat & at_quota);
    // A last beat that coincides with the quota is a normal finish, not a preemption.
    assign preempt_nxt = beat & at_quota & !bus.i_last;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= S_IDLE;
            r_grant_vec   <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_beat_cnt    <= '0;
            r_preempt     <= 1'b0;
            r_last_idx    <= IDX_W'(PORTS - 1);
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arb_found) begin
                        r_state       <= S_GRANT;
                        r_grant_vec   <= {{(PORTS-1){1'b0}}, 1'b1} << arb_idx;
                        r_grant_idx   <= arb_idx;
                        r_grant_valid <= 1'b1;
                        r_beat_cnt    <= '0;
                    end
                end
                S_GRANT: begin
                    if (grant_end) begin
                        r_state       <= S_IDLE;
                        r_grant_vec   <= '0;
                        r_grant_idx   <= '0;
                        r_grant_valid <= 1'b0;
                        r_beat_cnt    <= '0;
                        r_last_idx    <= r_grant_idx;
                        r_preempt     <= preempt_nxt;
                    end else if (beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_grant_vec   = r_grant_vec;
    assign bus.o_grant_idx   = r_grant_idx;
    assign bus.o_grant_valid = r_grant_valid;
    assign bus.o_beat_cnt    = r_beat_cnt;
    assign bus.o_preempt     = r_preempt;
endmodule

// File: doc/burst_rr_scheduler.md
# burst_rr_scheduler

Round-robin scheduler that shares one downstream resource between PORTS requesters. A port, once granted, keeps the resource for a whole burst of beats. The grant ends when the port drops its request, signals its last beat, or uses up its MAX_BURST quota; the scheduler then rotates fairly to the next requester. It sits in front of a shared bus or resource port and drives the select of the master-side mux.

## Interface
- PORTS, default 4: number of requesters; must be ≥ 2.
- MAX_BURST, default 8: maximum beats per grant; must be ≥ 1.
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_req_vec  in  PORTS  per-port request; held high while the port has beats to send.
- i_ready  in  1  downstream accepts a beat this cycle.
- i_last  in  1  granted port's current beat is its final one; already muxed by o_grant_idx.
- o_grant_vec  out  PORTS  one-hot grant, registered; all-zero when idle.
- o_grant_idx  out  $clog2(PORTS)  index of the granted port; 0 when idle.
- o_grant_valid  out  1  high when o_grant_vec is non-zero.
- o_beat_cnt  out  $clog2(MAX_BURST+1)  beats accepted in the current grant.
- o_preempt  out  1  one-cycle pulse: grant removed due to quota while the port still requests.

## Operation
- Beat definition: beat = o_grant_valid & i_req_vec[o_grant_idx] & i_ready.
- States:
  - IDLE: no grant.
  - GRANT: one port holds the resource.
- Reset values:
  - state = IDLE.
  - o_grant_vec = 0, o_grant_idx = 0, o_grant_valid = 0.
  - o_beat_cnt = 0, o_preempt = 0.
  - r_last_idx = PORTS-1, so port 0 wins the first arbitration.
- IDLE:
  - If |i_req_vec, select the first set bit searching upward from r_last_idx+1, wrapping modulo PORTS.
  - Next cycle: state = GRANT, grant registered on the selected port, o_beat_cnt = 0.
  - If no request: stay in IDLE with all outputs 0.
- GRANT: each beat increments o_beat_cnt. The grant ends at the clock edge after any of these conditions:
  - (a) i_req_vec[o_grant_idx] = 0 (release, no beat that cycle);
  - (b) beat & i_last;
  - (c) beat & o_beat_cnt == MAX_BURST-1 (quota reached).
- On grant end:
  - state = IDLE; grant outputs and o_beat_cnt clear.
  - r_last_idx = the outgoing o_grant_idx.
  - o_preempt = 1 for that one cycle only when (c) ended the grant, i_last = 0, and the port's request is still high.
- Priority when conditions coincide: (b) outranks (c) for o_preempt; otherwise they all end the grant identically.
- Stalls: while i_ready = 0 and the request stays high, the grant and count hold indefinitely. There is no timeout.
- Request changes:
  - Request bits of non-granted ports are ignored during GRANT.
  - A non-granted port changing its request never disturbs the current grant.
- Fairness: a port that was just granted is lowest priority at the next arbitration. Every continuously requesting port is therefore granted within PORTS-1 intervening grants.
- Reset mid-burst: the next rising edge with i_rstn = 0 restores all reset values, including r_last_idx. No partial-burst state survives.
- Round-robin index arithmetic is modulo PORTS for any PORTS, including non-powers of two.

## Timing
- Arbitration latency: request seen in IDLE at edge N → o_grant_vec valid after edge N+1 (1 cycle).
- Turnaround: exactly one IDLE cycle (grant all-zero) between any two consecutive grants, even to a different port.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- Request-to-grant combinational path: none; all outputs are registered.
- o_preempt is coincident with the first IDLE cycle after the grant.

## Test plan
- Single requester: PORTS=4, MAX_BURST=8. req=0001, i_ready=1, i_last on beat 3 → grant 0001 for 3 cycles, o_beat_cnt 0,1,2, then one idle cycle, then regrant 0001. o_preempt never asserts.
- Quota preemption: req=0011 held, i_ready=1, i_last=0 → grant sequence 0001 (8 beats), idle, 0010 (8 beats), idle, 0001. o_preempt pulses in each idle cycle.
- Rotation order after reset: req=1111 held, i_last=1 each beat → grants 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- Backpressure: grant port 2, i_ready=0 for 5 cycles, then 1 → grant holds, o_beat_cnt stays 0 during the stall, then counts normally.
- Release and wrap: port 3 granted, drops req after 2 beats while req=1001 otherwise → next grant is port 0 (wrap).
- Reset mid-burst: i_rstn=0 for 1 cycle during beat 4 of port 1 → all outputs 0 next cycle. With req=0011, the next grant goes to port 0.
